// File: rtl/pipelined_addsub.sv
// Skewed ripple-carry add/subtract pipeline. Each stage resolves one SEG-bit segment,
// and a single advance signal moves the whole pipeline forward or stalls it.
module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int STAGES = WIDTH / SEG;

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // Subtraction is a + ~b + !cin, so cout = 1 means no borrow.
    assign w_b_eff = sub ? ~b : b;
    assign w_c0    = sub ? ~cin : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] w_a;
        logic [WIDTH-1:0] w_b;
        logic [WIDTH-1:0] w_sum_in;
        logic [WIDTH-1:0] w_sum;
        logic             w_cin;
        logic             w_v;
        logic [SEG:0]     w_seg;

        logic             r_v;
        logic             r_c;
        logic [WIDTH-1:0] r_sum;

        if (k == 0) begin : g_src
            assign w_a      = a;
            assign w_b      = w_b_eff;
            assign w_sum_in = '0;
            assign w_cin    = w_c0;
            assign w_v      = in_valid;
        end else begin : g_src
            assign w_a      = g_stage[k-1].g_ops.r_a;
            assign w_b      = g_stage[k-1].g_ops.r_b;
            assign w_sum_in = g_stage[k-1].r_sum;
            assign w_cin    = g_stage[k-1].r_c;
            assign w_v      = g_stage[k-1].r_v;
        end

        assign w_seg = {1'b0, w_a[k*SEG +: SEG]} + {1'b0, w_b[k*SEG +: SEG]}
                     + {{SEG{1'b0}}, w_cin};

        always_comb begin
            w_sum                = w_sum_in;
            w_sum[k*SEG +: SEG]  = w_seg[SEG-1:0];
        end

        // Bubbles travel with the pipeline; the valid bit is loaded even when 0.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v   <= 1'b0;
                r_c   <= 1'b0;
                r_sum <= '0;
            end else if (w_adv) begin
                r_v   <= w_v;
                r_c   <= w_seg[SEG];
                r_sum <= w_sum;
            end
        end

        if (k < STAGES - 1) begin : g_ops
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a;
                    r_b <= w_b;
                end
            end
        end else begin : g_last
            logic r_ovf;
            logic r_zero;
            logic r_neg;
            logic w_unused_ops;

            // Only the sign bits of the addends matter once the top segment is summed.
            assign w_unused_ops = ^{w_a, w_b};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                    r_neg  <= 1'b0;
                end else if (w_adv) begin
                    r_ovf  <= (w_a[WIDTH-1] == w_b[WIDTH-1]) &&
                              (w_sum[WIDTH-1] != w_a[WIDTH-1]);
                    r_zero <= (w_sum == '0);
                    r_neg  <= w_sum[WIDTH-1];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_v;
    assign s         = g_stage[STAGES-1].r_sum;
    assign cout      = g_stage[STAGES-1].r_c;
    assign ovf       = g_stage[STAGES-1].g_last.r_ovf;
    assign zero      = g_stage[STAGES-1].g_last.r_zero;
    assign neg       = g_stage[STAGES-1].g_last.r_neg;

endmodule
